// File: rtl/processor_pkg.sv
// Shared definitions for the logic processor's serial command front end.
// Holds the command byte codes and the state encodings of the byte-level
// receiver and the packet-level decoder.
package processor_pkg;

  localparam logic [7:0] CMD_LOAD_A = 8'h41;  // 'A': next byte goes to register A
  localparam logic [7:0] CMD_LOAD_B = 8'h42;  // 'B': next byte goes to register B
  localparam logic [7:0] CMD_EXEC   = 8'h45;  // 'E': one compute/shift pass

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PKT_WAIT_CMD,
    PKT_WAIT_DATA,
    PKT_PULSE
  } pkt_state_t;

endpackage

// File: rtl/serial_cmd_loader_uart_rx.sv
// uart_rx_byte: 8N1 serial byte receiver.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   rx_i         serial line, already synchronized, idle high, LSB first
//   byte_valid_o one-cycle strobe, the cycle after a good stop sample
//   byte_data_o  received byte, valid with byte_valid_o
//   frame_err_o  one-cycle strobe, the cycle after a low stop sample
//   busy_o       high whenever the receiver is not idle
module uart_rx_byte
  import processor_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q;
  logic          rx_q;       // previous line value, for falling-edge detection
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic          ferr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      rx_q    <= 1'b1;   // line idles high; avoids a phantom edge out of reset
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_q    <= rx_i;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_i && rx_q) begin
            state_q <= RX_START;
            baud_q  <= '0;
          end
        end
        RX_START: begin
          if (baud_q == HALF_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            // Line back high at mid-start: treat as a glitch, silently.
            state_q <= rx_i ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            shift_q <= {rx_i, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            valid_q <= rx_i;
            ferr_q  <= !rx_i;
            // Back to IDLE right at mid-stop so a back-to-back start edge is caught.
            state_q <= RX_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // shift_q is untouched until the next frame's first data sample, long after
  // the strobe has been consumed, so it can feed the data output directly.
  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/serial_cmd_loader.sv
// serial_cmd_loader: turns a serial command stream into Din/LoadA/LoadB/Execute
// stimulus for the 8-bit logic processor.
// Ports:
//   Clk      system clock
//   Reset    synchronous active-high reset
//   Rx       synchronized serial input, idle high
//   Din      last loaded data byte
//   LoadA    PULSE_CYCLES-wide load pulse for register A
//   LoadB    PULSE_CYCLES-wide load pulse for register B
//   Execute  PULSE_CYCLES-wide execute pulse
//   Busy     frame in flight or packet incomplete
//   Err      one-cycle pulse on framing error or unknown command
module serial_cmd_loader
  import processor_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Din,
  output logic       LoadA,
  output logic       LoadB,
  output logic       Execute,
  output logic       Busy,
  output logic       Err
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .rx_i         (Rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err),
    .busy_o       (rx_busy)
  );

  pkt_state_t    state_q;
  logic          tgt_b_q;    // load target picked by the command byte
  logic [PW-1:0] pcnt_q;
  logic [7:0]    din_q;
  logic          loada_q, loadb_q, exec_q;
  logic          cmd_err_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= PKT_WAIT_CMD;
      tgt_b_q   <= 1'b0;
      pcnt_q    <= '0;
      din_q     <= '0;
      loada_q   <= 1'b0;
      loadb_q   <= 1'b0;
      exec_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        PKT_WAIT_CMD: begin
          if (byte_valid) begin
            case (byte_data)
              CMD_LOAD_A: begin state_q <= PKT_WAIT_DATA; tgt_b_q <= 1'b0; end
              CMD_LOAD_B: begin state_q <= PKT_WAIT_DATA; tgt_b_q <= 1'b1; end
              CMD_EXEC: begin
                state_q <= PKT_PULSE;
                pcnt_q  <= '0;
                exec_q  <= 1'b1;
              end
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        PKT_WAIT_DATA: begin
          // A broken data frame abandons the packet; the error itself is
          // reported straight from the receiver strobe.
          if (frame_err) begin
            state_q <= PKT_WAIT_CMD;
          end else if (byte_valid) begin
            din_q   <= byte_data;
            state_q <= PKT_PULSE;
            pcnt_q  <= '0;
            loada_q <= !tgt_b_q;
            loadb_q <= tgt_b_q;
          end
        end
        PKT_PULSE: begin
          if (pcnt_q == PULSE_LAST) begin
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            exec_q  <= 1'b0;
            state_q <= PKT_WAIT_CMD;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        default: state_q <= PKT_WAIT_CMD;
      endcase
    end
  end

  assign Din     = din_q;
  assign LoadA   = loada_q;
  assign LoadB   = loadb_q;
  assign Execute = exec_q;
  assign Busy    = rx_busy || (state_q != PKT_WAIT_CMD);
  // Both terms are registered one-cycle strobes and never coincide.
  assign Err     = cmd_err_q || frame_err;

endmodule

// File: tb/tb_serial_cmd_loader.sv
module tb_serial_cmd_loader;

  localparam int C = 8;
  localparam int P = 4;
  // Start bit driven right after edge e0: edge seen at e0+1, stop sample at
  // e0+1+C/2+9C = e0+77, strobe high after e0+77, pulse high after e0+78.
  localparam int STOP_OFS  = 77;
  localparam int PULSE_OFS = 78;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Rx = 1'b1;
  logic [7:0] Din;
  logic       LoadA, LoadB, Execute, Busy, Err;

  serial_cmd_loader #(.CLKS_PER_BIT(C), .PULSE_CYCLES(P)) dut (
    .Clk(Clk), .Reset(Reset), .Rx(Rx), .Din(Din), .LoadA(LoadA),
    .LoadB(LoadB), .Execute(Execute), .Busy(Busy), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Observation counters, written only by this monitor.
  int na = 0, nb = 0, ne = 0, nerr = 0, onehot_bad = 0, din_bad = 0;
  int la_rise = 0, lb_rise = 0, ex_rise = 0, err_rise = 0;
  logic [7:0] la_din = '0, lb_din = '0, pulse_din = '0;
  logic pa = 1'b0, pb = 1'b0, pe = 1'b0, perr = 1'b0;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (LoadA) na++;
      if (LoadB) nb++;
      if (Execute) ne++;
      if (Err) nerr++;
      if (int'(LoadA) + int'(LoadB) + int'(Execute) > 1) onehot_bad++;
      if (LoadA && !pa) begin la_rise = cyc; la_din = Din; pulse_din = Din; end
      if (LoadB && !pb) begin lb_rise = cyc; lb_din = Din; pulse_din = Din; end
      if (Execute && !pe) ex_rise = cyc;
      if (Err && !perr) err_rise = cyc;
      if ((LoadA || LoadB) && Din !== pulse_din) din_bad++;
    end
    pa = LoadA; pb = LoadB; pe = Execute; perr = Err;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int start_cyc;
  int s_na, s_nb, s_ne, s_nerr;

  task automatic snap();
    s_na = na; s_nb = nb; s_ne = ne; s_nerr = nerr;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    start_cyc = cyc;
    Rx = 1'b0; idle(C);
    for (int i = 0; i < 8; i++) begin Rx = b[i]; idle(C); end
    Rx = !bad_stop; idle(C);
    Rx = 1'b1;
  endtask

  initial begin
    idle(3);
    Reset = 1'b0;
    idle(2);

    // Reset state
    chk("rst_din", Din, 8'h00);
    chk("rst_loada", LoadA, 0);
    chk("rst_loadb", LoadB, 0);
    chk("rst_exec", Execute, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);

    // Load A
    snap();
    send_byte(8'h41, 0);
    chk("busy_wait_data", Busy, 1);
    send_byte(8'hA5, 0);
    idle(10);
    chk("la_din", Din, 8'hA5);
    chk("la_width", na - s_na, P);
    chk("la_latency", la_rise - start_cyc, PULSE_OFS);
    chk("la_no_b", nb - s_nb, 0);
    chk("la_no_e", ne - s_ne, 0);
    chk("la_no_err", nerr - s_nerr, 0);
    chk("la_busy_done", Busy, 0);

    // Data byte equal to a command code
    snap();
    send_byte(8'h42, 0);
    send_byte(8'h45, 0);
    idle(10);
    chk("lb_din", Din, 8'h45);
    chk("lb_width", nb - s_nb, P);
    chk("lb_no_exec", ne - s_ne, 0);

    // Execute, then unknown command
    snap();
    send_byte(8'h45, 0);
    idle(10);
    chk("ex_width", ne - s_ne, P);
    chk("ex_latency", ex_rise - start_cyc, PULSE_OFS);
    chk("ex_din_kept", Din, 8'h45);
    snap();
    send_byte(8'h7F, 0);
    idle(10);
    chk("unk_err", nerr - s_nerr, 1);
    chk("unk_err_time", err_rise - start_cyc, PULSE_OFS);
    chk("unk_no_pulse", (na - s_na) + (nb - s_nb) + (ne - s_ne), 0);
    chk("unk_busy", Busy, 0);

    // False start glitch
    snap();
    Rx = 1'b0; idle(3); Rx = 1'b1; idle(20);
    chk("glitch_no_err", nerr - s_nerr, 0);
    chk("glitch_busy", Busy, 0);

    // Framing error on the data byte
    send_byte(8'h41, 0);
    send_byte(8'h3C, 1);
    idle(10);
    chk("ferr_err", nerr - s_nerr, 1);
    chk("ferr_err_time", err_rise - start_cyc, STOP_OFS);
    chk("ferr_no_load", na - s_na, 0);
    chk("ferr_busy", Busy, 0);
    snap();
    send_byte(8'h41, 0);
    send_byte(8'h11, 0);
    idle(10);
    chk("recover_din", Din, 8'h11);
    chk("recover_la", na - s_na, P);

    // Back-to-back frames
    snap();
    send_byte(8'h41, 0);
    send_byte(8'h01, 0);
    send_byte(8'h42, 0);
    send_byte(8'h02, 0);
    idle(10);
    chk("b2b_la", na - s_na, P);
    chk("b2b_lb", nb - s_nb, P);
    chk("b2b_la_din", la_din, 8'h01);
    chk("b2b_lb_din", lb_din, 8'h02);
    chk("b2b_din", Din, 8'h02);
    chk("b2b_no_err", nerr - s_nerr, 0);

    // Reset during data bits
    Rx = 1'b0; idle(C);
    Rx = 1'b1; idle(C);
    Rx = 1'b0; idle(C / 2);
    chk("pre_rst_busy", Busy, 1);
    Reset = 1'b1; Rx = 1'b1;
    idle(1);
    chk("abort_din", Din, 8'h00);
    chk("abort_busy", Busy, 0);
    chk("abort_pulses", int'(LoadA) + int'(LoadB) + int'(Execute) + int'(Err), 0);
    Reset = 1'b0;
    idle(5);
    snap();
    send_byte(8'h42, 0);
    send_byte(8'h5A, 0);
    idle(10);
    chk("post_rst_din", Din, 8'h5A);
    chk("post_rst_lb", nb - s_nb, P);

    chk("onehot", onehot_bad, 0);
    chk("din_stable", din_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_cmd_loader.md
# serial_cmd_loader

Receives an 8N1 asynchronous serial command stream and converts it into the load/execute stimulus for the 8-bit logic processor, replacing the push-button and switch inputs. Each command byte selects an action. Load commands are followed by one data byte, which is presented on `Din` together with a stretched `LoadA`/`LoadB` pulse. The block sits at the top level between the board's serial input pin (after its synchronizer) and the processor's `Din`/`LoadA`/`LoadB`/`Execute` inputs; any polarity adaptation happens at the top level.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- `PULSE_CYCLES`, 4, width of every output command pulse; must be < `CLKS_PER_BIT`.
- `Clk`  input  1  system clock; single clock domain.
- `Reset`  input  1  synchronous, active-high reset.
- `Rx`  input  1  serial line, already synchronized to `Clk`; idle high, LSB first.
- `Din`  output  8  data value for the processor; holds the last loaded byte.
- `LoadA`  output  1  active-high pulse: load `Din` into register A.
- `LoadB`  output  1  active-high pulse: load `Din` into register B.
- `Execute`  output  1  active-high pulse: start one compute/shift pass.
- `Busy`  output  1  high while a frame is being received or a packet is incomplete.
- `Err`  output  1  one-cycle pulse on a framing error or an unknown command.

## Operation
- **Byte layer (RX FSM)**
  - States and transitions: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling `Rx` starts the mid-start timer.
  - START: `Rx` is sampled `CLKS_PER_BIT/2` cycles (integer division) after the falling edge.
    - Sample high: false start, return to IDLE with no error.
  - DATA: 8 samples, each `CLKS_PER_BIT` cycles apart, shifted in LSB first.
  - STOP: one sample.
    - High: byte valid.
    - Low: framing error. `Err` pulses, the byte is discarded, and the packet layer returns to WAIT_CMD.
- **Packet layer (PKT FSM)**
  - States: WAIT_CMD, WAIT_DATA, PULSE.
  - In WAIT_CMD:
    - 0x41 ('A') → WAIT_DATA with target A.
    - 0x42 ('B') → WAIT_DATA with target B.
    - 0x45 ('E') → PULSE on `Execute`.
    - Any other byte → `Err` pulse and stay in WAIT_CMD.
  - In WAIT_DATA, any byte value, including 0x41/0x42/0x45, is data: it is latched into `Din`, then PULSE on `LoadA` or `LoadB`.
  - PULSE: the selected output is high for exactly `PULSE_CYCLES` cycles, then the FSM returns to WAIT_CMD. Only one of `LoadA`/`LoadB`/`Execute` is ever high.
- `Din` changes only when a data byte is accepted, and is stable for the whole load pulse and afterwards.
- `Busy` = (RX state ≠ IDLE) OR (PKT state ≠ WAIT_CMD).
- Reset values: `Din`=0x00, `LoadA`=`LoadB`=`Execute`=0, `Busy`=0, `Err`=0. Both FSMs go to IDLE / WAIT_CMD and all counters to 0.
- Reset mid-frame or mid-pulse aborts immediately: the partial byte is discarded and an active pulse drops the next cycle.

## Timing
- Falling-edge detection uses a registered copy of `Rx`. The edge is seen in the cycle `Rx`=0 while the previous value was 1.
- The STOP sample occurs ≈ 9.5·`CLKS_PER_BIT` cycles after the falling edge. The byte-valid strobe is high for one cycle, one cycle after the STOP sample.
- A load/execute pulse asserts on the cycle after the byte-valid strobe. `Din` updates on that same edge.
- Because `PULSE_CYCLES` < `CLKS_PER_BIT`, every pulse ends before the next frame's stop bit. No byte is lost when frames are sent back-to-back with a single stop bit.
- `Err` asserts on the cycle after the offending sample or byte-valid strobe.
- The RX FSM accepts a new start bit in the cycle after the STOP sample, even while the packet layer is in PULSE.

## Structure
- Shared package `processor_pkg`:
  - Command constants `CMD_LOAD_A`=8'h41, `CMD_LOAD_B`=8'h42, `CMD_EXEC`=8'h45.
  - Enums `rx_state_t` and `pkt_state_t`.
- Natural sub-module: `uart_rx_byte`. It contains the RX FSM, bit counter, baud counter and shift register, and outputs `byte_valid`, `byte_data` and `frame_err`.
- `serial_cmd_loader` holds the packet FSM, the pulse counter and the `Din` register.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=8 and `PULSE_CYCLES`=4.
- **Load A:** send 0x41 then 0xA5 → `Din`=0xA5 and `LoadA` high exactly 4 cycles, starting 1 cycle after the second stop sample; `LoadB`=`Execute`=0; `Err` never pulses.
- **Data equal to a command code:** send 0x42 then 0x45 → `Din`=0x45 with a 4-cycle `LoadB` pulse; no `Execute` pulse.
- **Execute and unknown command:** send 0x45 → one 4-cycle `Execute` pulse, `Din` unchanged. Then send 0x7F → one-cycle `Err`, no pulses, `Busy` returns to 0.
- **False start and framing error:** a 3-cycle low glitch on `Rx` → no byte, no `Err`. Then send 0x41, then 0x3C with the stop bit forced low → `Err` pulses, no `LoadA`, and PKT returns to WAIT_CMD. A following 0x41, 0x11 produces `Din`=0x11 with a `LoadA` pulse.
- **Back-to-back and reset abort:** send frames 0x41, 0x01, 0x42, 0x02 with no idle gaps → both loads occur with correct `Din` values. Assert `Reset` during the DATA bits of a later frame → all outputs return to their reset values the next cycle, and a new packet after reset is received correctly.
